// File: rtl/guess_core_pkg.sv
// Shared encodings for the code-guessing game: phases, key codes and digit limits.
package guess_core_pkg;

  typedef enum logic [1:0] {
    PH_SECRET = 2'd0,
    PH_GUESS  = 2'd1,
    PH_SCORE  = 2'd2,
    PH_DONE   = 2'd3
  } phase_t;

  localparam logic [3:0] KEY_CLR     = 4'hC;
  localparam logic [3:0] KEY_ENT     = 4'hE;
  localparam logic [3:0] DIGIT_EMPTY = 4'hF;
  localparam logic [3:0] LAST_DIGIT  = 4'd9;

endpackage

// File: rtl/guess_scorer.sv
// Sequential A/B scorer: walks digit values 0..9, one per cycle, summing
// min(count in guess, count in secret); B is that total minus exact matches.
module guess_scorer
  import guess_core_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] secret,
  input  logic [4*N_DIGITS-1:0] guess,
  output logic                  done,
  output logic [3:0]            a_cnt,
  output logic [3:0]            b_cnt
);

  logic       busy;
  logic [3:0] digit;
  logic [3:0] total;
  logic [3:0] cnt_g;
  logic [3:0] cnt_s;
  logic [3:0] exact;
  logic [3:0] term;
  logic [3:0] total_next;

  always_comb begin
    cnt_g = '0;
    cnt_s = '0;
    exact = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (guess[4*i +: 4] == digit) cnt_g = cnt_g + 4'd1;
      if (secret[4*i +: 4] == digit) cnt_s = cnt_s + 4'd1;
      if (guess[4*i +: 4] == secret[4*i +: 4]) exact = exact + 4'd1;
    end
    term       = (cnt_g < cnt_s) ? cnt_g : cnt_s;
    total_next = total + term;
  end

  // start only arms the walk; guess/secret are sampled from the next cycle on
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      digit <= '0;
      total <= '0;
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        digit <= '0;
        total <= '0;
      end else if (busy) begin
        total <= total_next;
        digit <= digit + 4'd1;
        if (digit == LAST_DIGIT) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          a_cnt <= exact;
          b_cnt <= total_next - exact;
        end
      end
    end
  end

endmodule

// File: rtl/guess_core.sv
// Code-guessing game core: keypad entry of a secret and guesses, scoring via
// guess_scorer, try counting and win/lose tracking. All outputs are registered.
module guess_core
  import guess_core_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int MAX_TRIES    = 10,
  parameter int ALLOW_REPEAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  new_game,
  output logic [4*N_DIGITS-1:0] entry_buf,
  output logic [3:0]            entry_len,
  output logic [3:0]            a_cnt,
  output logic [3:0]            b_cnt,
  output logic                  result_valid,
  output logic [3:0]            tries,
  output logic                  win,
  output logic                  lose,
  output logic                  entry_err,
  output logic [1:0]            phase
);

  localparam logic [4*N_DIGITS-1:0] BUF_EMPTY = {N_DIGITS{DIGIT_EMPTY}};
  localparam logic [3:0]            LEN_FULL  = 4'(N_DIGITS);
  localparam logic [3:0]            TRIES_MAX = 4'(MAX_TRIES);

  phase_t                state;
  logic [4*N_DIGITS-1:0] secret;
  logic [4*N_DIGITS-1:0] guess;
  logic                  entering;
  logic                  is_dup;
  logic                  start_score;
  logic                  sc_done;
  logic [3:0]            sc_a;
  logic [3:0]            sc_b;

  assign phase = state;

  // Empty slots hold 4'hF, so scanning every slot cannot match a real digit
  always_comb begin
    is_dup = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (entry_buf[4*i +: 4] == key_code) is_dup = 1'b1;
    end
  end

  assign entering    = key_valid && !new_game && (state == PH_SECRET || state == PH_GUESS);
  assign start_score = entering && (state == PH_GUESS) && (key_code == KEY_ENT) &&
                       (entry_len == LEN_FULL);

  guess_scorer #(
    .N_DIGITS(N_DIGITS)
  ) u_scorer (
    .clk   (clk),
    .rst   (rst),
    .abort (new_game),
    .start (start_score),
    .secret(secret),
    .guess (guess),
    .done  (sc_done),
    .a_cnt (sc_a),
    .b_cnt (sc_b)
  );

  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state        <= PH_SECRET;
      entry_buf    <= BUF_EMPTY;
      entry_len    <= '0;
      a_cnt        <= '0;
      b_cnt        <= '0;
      tries        <= '0;
      win          <= 1'b0;
      lose         <= 1'b0;
      result_valid <= 1'b0;
      entry_err    <= 1'b0;
      secret       <= BUF_EMPTY;
      guess        <= BUF_EMPTY;
    end else begin
      result_valid <= 1'b0;
      entry_err    <= 1'b0;
      if (entering) begin
        if (key_code <= LAST_DIGIT) begin
          if (entry_len == LEN_FULL || (ALLOW_REPEAT == 0 && is_dup)) begin
            entry_err <= 1'b1;
          end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
              if (4'(i) == entry_len) entry_buf[4*i +: 4] <= key_code;
            end
            entry_len <= entry_len + 4'd1;
          end
        end else if (key_code == KEY_CLR) begin
          entry_buf <= BUF_EMPTY;
          entry_len <= '0;
        end else if (key_code == KEY_ENT) begin
          if (entry_len != LEN_FULL) begin
            entry_err <= 1'b1;
          end else begin
            entry_buf <= BUF_EMPTY;
            entry_len <= '0;
            if (state == PH_SECRET) begin
              secret <= entry_buf;
              state  <= PH_GUESS;
            end else begin
              guess <= entry_buf;
              state <= PH_SCORE;
            end
          end
        end
      end
      if (state == PH_SCORE && sc_done) begin
        result_valid <= 1'b1;
        a_cnt        <= sc_a;
        b_cnt        <= sc_b;
        if (tries != TRIES_MAX) tries <= tries + 4'd1;
        // A full match wins even when it is the last allowed try
        if (sc_a == LEN_FULL) begin
          win   <= 1'b1;
          state <= PH_DONE;
        end else if (tries + 4'd1 >= TRIES_MAX) begin
          lose  <= 1'b1;
          state <= PH_DONE;
        end else begin
          state <= PH_GUESS;
        end
      end
    end
  end

endmodule
